// File: rtl/sc_stream_counter.sv
// Stochastic-to-binary back end: counts ones over STREAM_LEN valid samples and hands the count out on valid/ready.
// Build option: define SC_STREAM_BIPOLAR_EN to return 2*ones - STREAM_LEN (two's complement) instead of the raw count.
module sc_stream_counter #(
  parameter int WIDTH      = 8,
  parameter int STREAM_LEN = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             stream_en,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             busy,
  output logic [WIDTH+1:0] result,
  output logic             result_valid,
  input  logic             result_ready
);

  // state   | meaning
  // S_IDLE  | waiting for start, result holds last value
  // S_COUNT | upstream enabled, accumulating valid samples
  // S_DONE  | result presented, waiting for result_ready
  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

  localparam logic [WIDTH:0] LEN = (WIDTH+1)'(STREAM_LEN);
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  state_t           state_q, state_d;
  logic [WIDTH:0]   sample_cnt_q, sample_cnt_d;
  logic [WIDTH:0]   ones_cnt_q, ones_cnt_d;
  logic [WIDTH+1:0] result_q, result_d;
  logic [WIDTH:0]   sample_inc;
  logic [WIDTH:0]   ones_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sample_cnt_q <= '0;
      ones_cnt_q   <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      ones_cnt_q   <= ones_cnt_d;
      result_q     <= result_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    ones_cnt_d   = ones_cnt_q;
    result_d     = result_q;
    sample_inc   = sample_cnt_q + ONE;
    ones_inc     = ones_cnt_q + {{WIDTH{1'b0}}, bit_in};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_COUNT;
          sample_cnt_d = '0;
          ones_cnt_d   = '0;
        end
      end
      S_COUNT: begin
        if (bit_valid) begin
          sample_cnt_d = sample_inc;
          ones_cnt_d   = ones_inc;
          if (sample_inc == LEN) begin
            state_d = S_DONE;
`ifdef SC_STREAM_BIPOLAR_EN
            result_d = {ones_inc, 1'b0} - {1'b0, LEN};
`else
            result_d = {1'b0, ones_inc};
`endif
          end
        end
      end
      S_DONE: begin
        if (result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stream_en    = (state_q == S_COUNT);
  assign busy         = (state_q == S_COUNT) || (state_q == S_DONE);
  assign result_valid = (state_q == S_DONE);
  assign result       = result_q;

endmodule

// File: tb/tb_sc_stream_counter.sv
// Bench for sc_stream_counter: random/patterned evaluations, expected results queued and checked by a handshake monitor.
module tb_sc_stream_counter;
  localparam int W   = 8;
  localparam int LEN = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, bit_in, bit_valid, result_ready;
  logic stream_en, busy, result_valid;
  logic [W+1:0] result;

  logic s_start, s_bit_in, s_bit_valid, s_ready;
  logic s_stream_en, s_busy, s_valid;
  logic [W+1:0] s_result;

  int total = 0;
  int bad   = 0;
  int pushes = 0;
  int pops   = 0;
  logic [W+1:0] exp_q[$];

  sc_stream_counter #(.WIDTH(W), .STREAM_LEN(LEN)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stream_en(stream_en),
    .bit_in(bit_in), .bit_valid(bit_valid), .busy(busy),
    .result(result), .result_valid(result_valid), .result_ready(result_ready)
  );

  sc_stream_counter #(.WIDTH(W), .STREAM_LEN(1)) u_short (
    .clk(clk), .rst(rst), .start(s_start), .stream_en(s_stream_en),
    .bit_in(s_bit_in), .bit_valid(s_bit_valid), .busy(s_busy),
    .result(s_result), .result_valid(s_valid), .result_ready(s_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: the evaluation value depends only on how many ones were seen in the window.
  function automatic logic [W+1:0] model(input int ones, input int len);
    int v;
`ifdef SC_STREAM_BIPOLAR_EN
    v = 2 * ones - len;
`else
    v = ones;
`endif
    return v[W+1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && result_valid === 1'b1 && result_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_unexpected: got result_valid with result %0d, expected no result", result);
      end else begin
        check("scoreboard_result", result, exp_q.pop_front());
        pops++;
      end
    end
  end

  // mode: 0 zeros, 1 ones, 2 alternating, 3 random; gap: 0 none, 1 every 4th cycle, 2 random
  task automatic run_eval(input int mode, input int gap, input int ready_delay, input bit poke_start);
    int n = 0, ones = 0, cyc = 0, en_cnt = 0;
    logic b, v;
    logic [W+1:0] e;
    result_ready = (ready_delay == 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    while (n < LEN) begin
      case (gap)
        1:       v = (cyc % 4 != 3);
        2:       v = ($urandom_range(0, 3) != 0);
        default: v = 1'b1;
      endcase
      case (mode)
        0:       b = 1'b0;
        1:       b = 1'b1;
        2:       b = (n % 2 == 0);
        default: b = 1'($urandom_range(0, 1));
      endcase
      bit_valid = v;
      bit_in    = v ? b : 1'($urandom_range(0, 1));
      start     = poke_start && (cyc == 40);
      if (stream_en === 1'b1) en_cnt++;
      tick();
      if (v) begin
        n++;
        if (b) ones++;
      end
      cyc++;
    end
    bit_valid = 1'b0;
    start     = 1'b0;
    e = model(ones, LEN);
    exp_q.push_back(e);
    pushes++;
    if (gap == 1) check("window_cycles", cyc, LEN + (LEN - 1) / 3);
    check("stream_en_cycles", en_cnt, cyc);
    check("latency_valid", result_valid, 1);
    check("done_stream_en", stream_en, 0);
    check("done_busy", busy, 1);
    for (int i = 0; i < ready_delay; i++) begin
      check("held_valid", result_valid, 1);
      check("held_result", result, e);
      tick();
    end
    result_ready = 1'b1;
    tick();
    check("idle_valid", result_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_result_kept", result, e);
  endtask

  task automatic reset_midcount();
    result_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    bit_in = 1'b1;
    bit_valid = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bit_valid = 1'b0;
    check("rst_stream_en", stream_en, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    for (int i = 0; i < 3; i++) tick();
    check("rst_no_valid_later", result_valid, 0);
  endtask

  task automatic short_eval(input logic b);
    s_ready = 1'b1;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_bit_in = b;
    s_bit_valid = 1'b1;
    tick();
    s_bit_valid = 1'b0;
    check("short_valid", s_valid, 1);
    check("short_result", s_result, model(b ? 1 : 0, 1));
    tick();
    check("short_valid_drop", s_valid, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; result_ready = 1'b1;
    s_start = 1'b0; s_bit_in = 1'b0; s_bit_valid = 1'b0; s_ready = 1'b1;
    tick();
    tick();
    check("reset_stream_en", stream_en, 0);
    check("reset_busy", busy, 0);
    check("reset_valid", result_valid, 0);
    check("reset_result", result, 0);
    rst = 1'b0;
    tick();

    run_eval(1, 0, 0, 1'b0);
    run_eval(2, 1, 0, 1'b0);
    run_eval(0, 0, 5, 1'b0);
    reset_midcount();
    run_eval(3, 0, 0, 1'b1);
    for (int k = 0; k < 3; k++) run_eval(3, 2, $urandom_range(0, 3), 1'b0);

    short_eval(1'b1);
    short_eval(1'b0);

    for (int i = 0; i < 3; i++) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    check("scoreboard_pops", pops, pushes);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sc_stream_counter.md
Name: sc_stream_counter

Overview:
- Stochastic-to-binary back end; sits directly downstream of the stochastic circuit stage.
- Consumes that stage's 1-bit output bitstream.
- Counts ones over a fixed window of STREAM_LEN valid samples and returns the count as a binary result through a valid/ready handshake.
- Drives stream_en so the upstream LFSR/comparator stage advances only while an evaluation is running.

Parameters:
- WIDTH, 8, binary resolution; LFSR/comparator width of the upstream stage.
- STREAM_LEN, 256, samples per evaluation; legal range 1..2**WIDTH.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin an evaluation; sampled only in IDLE.
- stream_en  output  1  high in COUNT; upstream stage advances on it.
- bit_in  input  1  stochastic bit from the upstream circuit output.
- bit_valid  input  1  bit_in is a valid sample this cycle.
- busy  output  1  high in COUNT or DONE.
- result  output  WIDTH+2  ones count (unsigned), or bipolar value (see Optional Feature).
- result_valid  output  1  result holds a completed evaluation.
- result_ready  input  1  consumer accepts result.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; stream_en, busy, result_valid = 0; result = 0; internal counters = 0.
  - Reset has priority over all other inputs, including mid-COUNT and mid-DONE. A partial evaluation is discarded; no result_valid follows.
- Internal registers:
  - sample_cnt: WIDTH+1 bits, counts 0..STREAM_LEN.
  - ones_cnt: WIDTH+1 bits, counts 0..STREAM_LEN; cannot overflow.
- IDLE:
  - Outputs idle.
  - start=1 -> next state COUNT; sample_cnt and ones_cnt cleared on that edge.
  - result keeps its last value.
- COUNT:
  - stream_en=1, busy=1.
  - Each cycle with bit_valid=1: sample_cnt+1; ones_cnt+bit_in.
  - Cycles with bit_valid=0 change nothing; the window stretches.
  - start is ignored.
  - The edge that samples the STREAM_LEN-th valid bit:
    - result <= final ones count, including that bit.
    - State -> DONE.
    - result_valid = 1 from the next cycle.
  - Latency: result_valid rises exactly 1 cycle after the last valid sample.
- DONE:
  - stream_en=0, busy=1, result_valid=1.
  - result is held stable until the handshake completes.
  - result_valid & result_ready at an edge -> IDLE; result_valid=0 the following cycle.
  - start in DONE is ignored; start must be reasserted in IDLE.
  - bit_valid in DONE is ignored.
- Result encoding, unipolar (default):
  - result = {1'b0, ones_cnt}, zero-extended to WIDTH+2.
  - Value range 0..STREAM_LEN.
- Boundaries:
  - STREAM_LEN=1: a single valid sample completes the evaluation.
  - All-ones stream: result=STREAM_LEN.
  - All-zeros stream: result=0.
  - result_ready held high in DONE: 1-cycle result_valid pulse.
- Minimum evaluation period: STREAM_LEN + 2 cycles (start edge, samples, DONE cycle).

Optional Feature:
- Macro: SC_STREAM_BIPOLAR_EN.
- Defined:
  - result = 2*ones_cnt - STREAM_LEN, WIDTH+2-bit two's complement.
  - Range -STREAM_LEN..+STREAM_LEN.
  - Computed on the capture edge; same latency.
- Undefined: unipolar encoding as above. Port width is identical in both builds.

Test Plan:
- Ones stream:
  - Stimulus: STREAM_LEN=256; rst 2 cycles; start 1 cycle; bit_in=1, bit_valid=1 for 256 cycles; result_ready=1.
  - Response: result_valid pulses 1 cycle after the 256th sample; result=256 (0x100); stream_en high for exactly 256 cycles.
- Alternating stream with gaps:
  - Stimulus: alternating 1,0 with bit_valid low every 4th cycle.
  - Response: result=128 after 256 valid samples; the window spans 341 cycles; stream_en stays high throughout COUNT.
- Backpressure:
  - Stimulus: result_ready=0 for 5 cycles after completion, then 1.
  - Response: result_valid and result held 5 cycles; returns to IDLE one edge after ready; busy drops with it.
- Reset and start ordering:
  - Stimulus: rst asserted after 100 valid samples.
  - Response: next cycle IDLE, stream_en=0, result=0, no result_valid.
  - Stimulus: start pulsed during COUNT.
  - Response: no restart; count unaffected.
- Bipolar build (SC_STREAM_BIPOLAR_EN defined):
  - All-zeros stream: result=0x300 (-256).
  - All-ones stream: result=0x100 (+256).
  - 50% stream: result=0.
- Short window:
  - Stimulus: STREAM_LEN=1, bit_in=1.
  - Response: result=1, result_valid 1 cycle after the single sample.
